// File: rtl/sadd_seq_pkg.sv
// Purpose : shared types and default sizing for the sequential signed-add reducer.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package sadd_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_NUM_OPS = 16;
    localparam int DEF_IN_W    = 8;
    localparam int DEF_OUT_W   = 32;
    localparam int DEF_IDX_W   = $clog2(DEF_NUM_OPS);

endpackage

// File: rtl/sadd_seq_ctrl_sadd.sv
// Purpose : two-input signed adder; the single adder shared by the reducer.
// Latency : combinational, zero cycles.
// Backpressure: none; pure datapath.
//
// Ports: a, b - W-bit two's-complement addends; sum - a + b, wrapping modulo 2^W.
module sadd #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Two's-complement wrap is the intended overflow behaviour.
    assign sum = a + b;

endmodule

// File: rtl/sadd_seq_ctrl.sv
// Purpose : reduces up to NUM_OPS masked signed operands to one sum with one shared adder.
// Latency : NUM_OPS+1 cycles from the start edge to the done pulse, independent of the mask.
// Backpressure: none; start is ignored (not queued) while busy, result holds until next done.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset (aborts any run, clears result)
//   start      - begin a reduction; sampled only while idle
//   op_mask    - bit i includes operand i in the sum
//   ops        - packed operands, operand i at ops[i*IN_W +: IN_W]
//   busy       - high while accumulating and during the done cycle
//   done       - one-cycle pulse, final_sum valid in that cycle
//   final_sum  - signed result, held until the next done ('final' is a reserved word)
//   sel        - operand index being processed while accumulating, 0 otherwise
module sadd_seq_ctrl
    import sadd_seq_pkg::*;
#(
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int IDX_W   = $clog2(NUM_OPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NUM_OPS-1:0]      op_mask,
    input  logic [NUM_OPS*IN_W-1:0] ops,
    output logic                    busy,
    output logic                    done,
    output logic [OUT_W-1:0]        final_sum,
    output logic [IDX_W-1:0]        sel
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

    state_t                    state;
    logic [OUT_W-1:0]          acc;
    logic [IDX_W-1:0]          idx;
    logic [NUM_OPS-1:0]        mask_q;
    logic [NUM_OPS*IN_W-1:0]   ops_q;

    logic [IN_W-1:0]           op_cur;
    logic [OUT_W-1:0]          op_ext;
    logic [OUT_W-1:0]          add_sum;

    // Operand mux works from the snapshot so inputs may change mid-run.
    assign op_cur = ops_q[idx*IN_W +: IN_W];
    assign op_ext = {{(OUT_W-IN_W){op_cur[IN_W-1]}}, op_cur};

    sadd #(
        .W (OUT_W)
    ) u_sadd (
        .a   (acc),
        .b   (op_ext),
        .sum (add_sum)
    );

    // idx is forced back to 0 whenever the run ends, so gating with the
    // state only matters for clarity of the debug view.
    assign sel = (state == ACCUM) ? idx : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            mask_q    <= '0;
            ops_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            final_sum <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mask_q <= op_mask;
                        ops_q  <= ops;
                        acc    <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= ACCUM;
                    end
                end

                ACCUM: begin
                    if (mask_q[idx]) begin
                        acc <= add_sum;
                    end
                    if (idx == LAST_IDX) begin
                        // Result must include the last term, which acc has not absorbed yet.
                        final_sum <= mask_q[idx] ? add_sum : acc;
                        idx       <= '0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sadd_seq_ctrl.sv
// Purpose : directed scoreboard bench for sadd_seq_ctrl.
// Latency : n/a.
// Backpressure: n/a.
module tb_sadd_seq_ctrl;

    localparam int NUM_OPS = 16;
    localparam int IN_W    = 8;
    localparam int OUT_W   = 32;
    localparam int IDX_W   = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [NUM_OPS-1:0]      op_mask;
    logic [NUM_OPS*IN_W-1:0] ops;
    logic                    busy;
    logic                    done;
    logic [OUT_W-1:0]        final_sum;
    logic [IDX_W-1:0]        sel;

    sadd_seq_ctrl #(
        .NUM_OPS (NUM_OPS),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op_mask   (op_mask),
        .ops       (ops),
        .busy      (busy),
        .done      (done),
        .final_sum (final_sum),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OUT_W-1:0] sum;
        int               cyc;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected run,
    // both in result and in the cycle it appears.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_final", final_sum, e.sum);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_all_ops(input logic [IN_W-1:0] v);
        for (int i = 0; i < NUM_OPS; i++) ops[i*IN_W +: IN_W] = v;
    endtask

    // Issues a one-cycle start from IDLE; done is due 16 edges after the
    // start edge, i.e. in the 17th cycle following it.
    task automatic start_run(input logic [NUM_OPS-1:0] m, input logic [OUT_W-1:0] exp_sum,
                             input bit expect_done);
        exp_t e;
        op_mask = m;
        start   = 1'b1;
        tick(1);
        start   = 1'b0;
        if (expect_done) begin
            e.sum = exp_sum;
            e.cyc = cyc + NUM_OPS;
            sb.push_back(e);
        end
    endtask

    initial begin
        int busy_cnt;
        int c0;
        exp_t e;

        rst     = 1'b1;
        start   = 1'b1;
        op_mask = '1;
        set_all_ops(8'd1);

        // Reset held with start high: nothing may begin.
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_final", final_sum, 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick(3);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Empty mask, plus a start pulse mid-run that must be ignored.
        start_run('0, 32'd0, 1'b1);
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(16);
        chk("empty_drained", 32'(sb.size()), 32'd0);
        chk("empty_idle_busy", 32'(busy), 32'd0);

        // Full mask, ops[i] = i+1 -> 136; busy for 17 cycles, sel tracks index.
        for (int i = 0; i < NUM_OPS; i++) ops[i*IN_W +: IN_W] = 8'(i + 1);
        start_run(16'hFFFF, 32'd136, 1'b1);
        busy_cnt = 0;
        for (int k = 0; k < 18; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (k == 5) chk("sel_mid", 32'(sel), 32'd5);
            tick(1);
        end
        chk("full_busy_len", 32'(busy_cnt), 32'd17);
        chk("full_drained", 32'(sb.size()), 32'd0);
        chk("idle_sel", 32'(sel), 32'd0);

        // All -128 with slot 10 skipped -> -1920.
        set_all_ops(8'h80);
        start_run(16'hFBFF, 32'hFFFFF880, 1'b1);
        tick(18);
        chk("neg_drained", 32'(sb.size()), 32'd0);

        // Same run, operands changed after start: snapshot keeps -1920.
        set_all_ops(8'h80);
        start_run(16'hFBFF, 32'hFFFFF880, 1'b1);
        tick(1);
        set_all_ops(8'd5);
        tick(17);
        chk("snap_drained", 32'(sb.size()), 32'd0);
        chk("snap_final_hold", final_sum, 32'hFFFFF880);

        // Reset mid-run: no done, result cleared.
        set_all_ops(8'd1);
        start_run(16'hFFFF, 32'd0, 1'b0);
        tick(7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_final", final_sum, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sel", 32'(sel), 32'd0);
        tick(20);
        start_run(16'hFFFF, 32'd16, 1'b1);
        tick(18);
        chk("fresh_drained", 32'(sb.size()), 32'd0);

        // Start held high: three runs, one every 18 cycles, each 32.
        set_all_ops(8'd2);
        op_mask = 16'hFFFF;
        start   = 1'b1;
        tick(1);
        c0 = cyc;
        for (int r = 0; r < 3; r++) begin
            e.sum = 32'd32;
            e.cyc = c0 + NUM_OPS + r * (NUM_OPS + 2);
            sb.push_back(e);
        end
        tick(36);
        start = 1'b0;
        tick(20);
        chk("b2b_drained", 32'(sb.size()), 32'd0);
        chk("b2b_idle_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
